// File: rtl/aes_block_serializer.sv
// Parallel-to-serial front end for the bit-serial AES core.
// Buffers whole blocks in a small FIFO and shifts each one out LSB first.
module aes_block_serializer #(
  parameter int BLOCK_W    = 128,
  parameter int FIFO_DEPTH = 2,
  parameter int GAP_CYCLES = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               EN,
  input  logic [BLOCK_W-1:0] IN_DATA,
  input  logic               IN_VALID,
  output logic               IN_READY,
  output logic               SOUT,
  output logic               SOUT_VAL,
  output logic               SOUT_LAST,
  output logic               BUSY,
  output logic [15:0]        BLK_CNT
);

  localparam int CNT_W  = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_W = $clog2(FIFO_DEPTH + 1);
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(BLOCK_W - 1);
  localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  logic [BLOCK_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [FILL_W-1:0]  fill;

  state_t             state;
  logic [BLOCK_W-1:0] sreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [15:0]        blk_cnt;

  logic fifo_empty;
  logic push;
  logic pop;
  logic last_bit_done;

  assign fifo_empty    = (fill == '0);
  assign IN_READY      = !reset_n && (fill != FULL_LVL);
  assign push          = IN_VALID && IN_READY;
  assign last_bit_done = (state == SHIFT) && EN && (bit_cnt == LAST_BIT);

  // With no gap the next block is loaded on the same edge that finishes the
  // current one, so the serial stream has no bubble between blocks.
  assign pop = EN && !fifo_empty &&
               ((state == IDLE) || (last_bit_done && (GAP_CYCLES == 0)));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= IN_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // The IDLE cycle that pops the next block is the final idle cycle of a gap,
  // so GAP itself lasts GAP_CYCLES-1 cycles and GAP_CYCLES=1 skips it.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      blk_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            sreg    <= fifo_mem[rd_ptr];
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (EN) begin
            if (bit_cnt == LAST_BIT) begin
              blk_cnt <= blk_cnt + 16'd1;
              bit_cnt <= '0;
              if (pop) begin
                sreg <= fifo_mem[rd_ptr];
              end else begin
                sreg <= sreg >> 1;
                if (GAP_CYCLES > 1) begin
                  gap_cnt <= GAP_LOAD;
                  state   <= GAP;
                end else begin
                  state <= IDLE;
                end
              end
            end else begin
              sreg    <= sreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (EN) begin
            gap_cnt <= gap_cnt - 1'b1;
            if (gap_cnt == GAP_W'(1)) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign SOUT_VAL  = (state == SHIFT) && EN;
  assign SOUT      = SOUT_VAL && sreg[0];
  assign SOUT_LAST = last_bit_done;
  assign BUSY      = (state != IDLE) || !fifo_empty;
  assign BLK_CNT   = blk_cnt;

endmodule

// File: tb/tb_aes_block_serializer.sv
// Directed bench for aes_block_serializer: one back-to-back instance and one
// with a 3-cycle inter-block gap, both logged every cycle on the falling edge.
module tb_aes_block_serializer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         en;
  logic [127:0] in_data;
  logic         in_valid;
  logic         in_valid_g;

  logic         in_ready, sout, sout_val, sout_last, busy;
  logic [15:0]  blk_cnt;
  logic         in_ready_g, sout_g, sout_val_g, sout_last_g, busy_g;
  logic [15:0]  blk_cnt_g;

  int checks = 0;
  int errors = 0;
  int framing_err = 0;
  int framing_err_g = 0;

  logic m_val[$], m_bit[$], m_last[$];
  logic g_val[$], g_bit[$], g_last[$];

  localparam logic [127:0] V1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BB = 128'hdeadbeef0badf00dcafef00d12345678;
  localparam logic [127:0] BC = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
  localparam logic [127:0] D3 = 128'ha5a5_0000_1111_2222_2d00_0000_0000_00ff;
  localparam logic [127:0] BX = 128'h0f0f0f0f_12345678_9abcdef0_c3c3c3c3;
  localparam logic [127:0] BY = 128'h80000000_00000001_55aa55aa_ffff0000;
  localparam logic [127:0] BP = 128'hcafebabe_cafebabe_cafebabe_cafebabe;
  localparam logic [127:0] BQ = 128'h13579bdf_2468ace0_13579bdf_2468ace0;

  always #5 clk = ~clk;

  aes_block_serializer #(.BLOCK_W(128), .FIFO_DEPTH(2), .GAP_CYCLES(0)) dut (
    .clk(clk), .reset_n(reset_n), .EN(en), .IN_DATA(in_data), .IN_VALID(in_valid),
    .IN_READY(in_ready), .SOUT(sout), .SOUT_VAL(sout_val), .SOUT_LAST(sout_last),
    .BUSY(busy), .BLK_CNT(blk_cnt)
  );

  aes_block_serializer #(.BLOCK_W(128), .FIFO_DEPTH(2), .GAP_CYCLES(3)) dut_gap (
    .clk(clk), .reset_n(reset_n), .EN(en), .IN_DATA(in_data), .IN_VALID(in_valid_g),
    .IN_READY(in_ready_g), .SOUT(sout_g), .SOUT_VAL(sout_val_g), .SOUT_LAST(sout_last_g),
    .BUSY(busy_g), .BLK_CNT(blk_cnt_g)
  );

  // Record one entry per clock cycle, mid-cycle, for later analysis.
  always @(negedge clk) begin
    m_val.push_back(sout_val);
    m_bit.push_back(sout);
    m_last.push_back(sout_last);
    g_val.push_back(sout_val_g);
    g_bit.push_back(sout_g);
    g_last.push_back(sout_last_g);
    if ((sout && !sout_val) || (sout_last && !sout_val)) framing_err++;
    if ((sout_g && !sout_val_g) || (sout_last_g && !sout_val_g)) framing_err_g++;
  end

  task automatic checkOutput(input string tag, input logic [383:0] observed,
                             input logic [383:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic runCycles(input int n);
    repeat (n) step();
  endtask

  task automatic clearLogs();
    m_val.delete(); m_bit.delete(); m_last.delete();
    g_val.delete(); g_bit.delete(); g_last.delete();
  endtask

  task automatic doReset();
    reset_n    = 1'b1;
    en         = 1'b0;
    in_valid   = 1'b0;
    in_valid_g = 1'b0;
    runCycles(2);
    reset_n = 1'b0;
    #1;
  endtask

  task automatic applyStimulus(input logic [127:0] data, input bit to_gap);
    in_data = data;
    if (to_gap) in_valid_g = 1'b1;
    else        in_valid   = 1'b1;
    step();
    in_valid   = 1'b0;
    in_valid_g = 1'b0;
  endtask

  function automatic logic valAt(input int which, input int i);
    return (which != 0) ? g_val[i] : m_val[i];
  endfunction

  task automatic analyzeLog(input int which, output int first, output int nval,
                            output int bubbles, output int nlast, output int first_last,
                            output int gap_after_last, output logic [383:0] bits);
    int n;
    int last_val_idx;
    logic b, l;
    n = (which != 0) ? g_val.size() : m_val.size();
    first = -1; nval = 0; nlast = 0; first_last = -1; last_val_idx = -1;
    bits = '0;
    for (int i = 0; i < n; i++) begin
      b = (which != 0) ? g_bit[i] : m_bit[i];
      l = (which != 0) ? g_last[i] : m_last[i];
      if (valAt(which, i)) begin
        if (first < 0) first = i;
        if (nval < 384) bits[nval] = b;
        nval++;
        last_val_idx = i;
      end
      if (l) begin
        if (first_last < 0) first_last = i;
        nlast++;
      end
    end
    bubbles = (first < 0) ? 0 : (last_val_idx - first + 1) - nval;
    gap_after_last = -1;
    if (first_last >= 0) begin
      gap_after_last = 0;
      for (int i = first_last + 1; i < n && !valAt(which, i); i++) gap_after_last++;
    end
  endtask

  initial begin
    int first, nval, bubbles, nlast, first_last, gap_len, quiet;
    logic [383:0] bits;
    logic [127:0] d3_word;

    reset_n = 1'b1; en = 1'b0; in_valid = 1'b0; in_valid_g = 1'b0; in_data = '0;
    runCycles(3);
    checkOutput("reset_in_ready", 384'(in_ready), 384'(0));
    checkOutput("reset_sout_val", 384'(sout_val), 384'(0));
    checkOutput("reset_sout_last", 384'(sout_last), 384'(0));
    checkOutput("reset_sout", 384'(sout), 384'(0));
    checkOutput("reset_busy", 384'(busy), 384'(0));
    checkOutput("reset_blk_cnt", 384'(blk_cnt), 384'(0));
    reset_n = 1'b0;
    #1;
    checkOutput("ready_after_release", 384'(in_ready), 384'(1));

    // Single block: latency, bit order, framing and count.
    en = 1'b1;
    clearLogs();
    applyStimulus(V1, 1'b0);
    checkOutput("t1_busy_queued", 384'(busy), 384'(1));
    checkOutput("t1_no_val_before_pop", 384'(sout_val), 384'(0));
    runCycles(140);
    analyzeLog(0, first, nval, bubbles, nlast, first_last, gap_len, bits);
    checkOutput("t1_first_idx", 384'(first), 384'(2));
    checkOutput("t1_nval", 384'(nval), 384'(128));
    checkOutput("t1_bubbles", 384'(bubbles), 384'(0));
    checkOutput("t1_first8", 384'(bits[7:0]), 384'(8'b0011_0100));
    checkOutput("t1_word", 384'(bits[127:0]), 384'(V1));
    checkOutput("t1_nlast", 384'(nlast), 384'(1));
    checkOutput("t1_last_pos", 384'(first_last), 384'(129));
    checkOutput("t1_blk_cnt", 384'(blk_cnt), 384'(1));
    checkOutput("t1_busy_done", 384'(busy), 384'(0));

    // Three blocks, FIFO fills while the engine is frozen, then streams.
    doReset();
    in_data = BA; in_valid = 1'b1; #1;
    checkOutput("t2_ready_c0", 384'(in_ready), 384'(1));
    step();
    in_data = BB; #1;
    checkOutput("t2_ready_c1", 384'(in_ready), 384'(1));
    step();
    in_data = BC; #1;
    checkOutput("t2_full", 384'(in_ready), 384'(0));
    step();
    en = 1'b1;
    clearLogs();
    #1;
    checkOutput("t2_full_before_pop", 384'(in_ready), 384'(0));
    step();
    checkOutput("t2_ready_after_pop", 384'(in_ready), 384'(1));
    step();
    in_valid = 1'b0;
    runCycles(400);
    analyzeLog(0, first, nval, bubbles, nlast, first_last, gap_len, bits);
    checkOutput("t2_first_idx", 384'(first), 384'(1));
    checkOutput("t2_nval", 384'(nval), 384'(384));
    checkOutput("t2_bubbles", 384'(bubbles), 384'(0));
    checkOutput("t2_nlast", 384'(nlast), 384'(3));
    checkOutput("t2_stream", bits, {BC, BB, BA});
    checkOutput("t2_blk_cnt", 384'(blk_cnt), 384'(3));

    // EN dropped for 5 cycles at bit 60.
    doReset();
    d3_word = D3;
    en = 1'b1;
    clearLogs();
    applyStimulus(D3, 1'b0);
    runCycles(61);
    en = 1'b0;
    runCycles(5);
    en = 1'b1;
    runCycles(140);
    quiet = 0;
    for (int i = 62; i <= 66; i++) if (m_val[i]) quiet++;
    checkOutput("t3_frozen_val", 384'(quiet), 384'(0));
    checkOutput("t3_resume_val", 384'(m_val[67]), 384'(1));
    checkOutput("t3_resume_bit60", 384'(m_bit[67]), 384'(d3_word[60]));
    checkOutput("t3_bit59", 384'(m_bit[61]), 384'(d3_word[59]));
    analyzeLog(0, first, nval, bubbles, nlast, first_last, gap_len, bits);
    checkOutput("t3_nval", 384'(nval), 384'(128));
    checkOutput("t3_bubbles", 384'(bubbles), 384'(5));
    checkOutput("t3_word", 384'(bits[127:0]), 384'(D3));
    checkOutput("t3_blk_cnt", 384'(blk_cnt), 384'(1));

    // Gap instance: two queued blocks separated by exactly 3 idle cycles.
    doReset();
    en = 1'b1;
    clearLogs();
    applyStimulus(BX, 1'b1);
    applyStimulus(BY, 1'b1);
    runCycles(300);
    analyzeLog(1, first, nval, bubbles, nlast, first_last, gap_len, bits);
    checkOutput("t4_first_idx", 384'(first), 384'(2));
    checkOutput("t4_nval", 384'(nval), 384'(256));
    checkOutput("t4_nlast", 384'(nlast), 384'(2));
    checkOutput("t4_gap_len", 384'(gap_len), 384'(3));
    checkOutput("t4_stream", 384'(bits[255:0]), 384'({BY, BX}));
    checkOutput("t4_blk_cnt", 384'(blk_cnt_g), 384'(2));
    checkOutput("t4_busy_done", 384'(busy_g), 384'(0));

    // Reset at bit 70 with a second block still queued.
    doReset();
    en = 1'b1;
    applyStimulus(BP, 1'b0);
    applyStimulus(BQ, 1'b0);
    runCycles(70);
    checkOutput("t5_shifting", 384'(sout_val), 384'(1));
    reset_n = 1'b1;
    step();
    checkOutput("t5_rst_val", 384'(sout_val), 384'(0));
    checkOutput("t5_rst_last", 384'(sout_last), 384'(0));
    checkOutput("t5_rst_sout", 384'(sout), 384'(0));
    checkOutput("t5_rst_busy", 384'(busy), 384'(0));
    checkOutput("t5_rst_blk_cnt", 384'(blk_cnt), 384'(0));
    checkOutput("t5_rst_ready", 384'(in_ready), 384'(0));
    reset_n = 1'b0;
    clearLogs();
    runCycles(200);
    analyzeLog(0, first, nval, bubbles, nlast, first_last, gap_len, bits);
    checkOutput("t5_no_residual", 384'(nval), 384'(0));
    checkOutput("t5_blk_cnt", 384'(blk_cnt), 384'(0));
    checkOutput("t5_busy", 384'(busy), 384'(0));

    // Block counter wraps from 0xFFFF to 0x0000.
    doReset();
    force dut.blk_cnt = 16'hffff;
    step();
    release dut.blk_cnt;
    #1;
    checkOutput("t6_preset", 384'(blk_cnt), 384'(16'hffff));
    en = 1'b1;
    applyStimulus(V1, 1'b0);
    runCycles(140);
    checkOutput("t6_wrap", 384'(blk_cnt), 384'(0));

    checkOutput("framing_main", 384'(framing_err), 384'(0));
    checkOutput("framing_gap", 384'(framing_err_g), 384'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/aes_block_serializer.md
Name: aes_block_serializer

Overview:
- Parallel-to-serial front end for the bit-serial AES core.
- Accepts 128-bit plaintext/ciphertext blocks over a valid/ready handshake and buffers them in a small FIFO.
- Emits each block one bit per clock, LSB first, as the core's DIN stream, with a framing valid strobe and a last-bit marker.
- Sits between the host-side block source and the Cipher DIN/EN inputs.

Parameters:
- BLOCK_W, 128, block width in bits; the counter width is derived as clog2(BLOCK_W).
- FIFO_DEPTH, 2, number of buffered input blocks (power of 2, at least 2).
- GAP_CYCLES, 0, idle cycles forced between consecutive blocks (0 = back-to-back).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  reset, synchronous and active-high (1 = reset) despite the name.
- EN  in  1  global enable; 0 freezes the serial engine.
- IN_DATA  in  BLOCK_W  block to serialize; bit 0 is sent first.
- IN_VALID  in  1  IN_DATA valid.
- IN_READY  out  1  FIFO can accept a block.
- SOUT  out  1  serial data, drives Cipher DIN.
- SOUT_VAL  out  1  SOUT carries a live bit this cycle.
- SOUT_LAST  out  1  SOUT is bit BLOCK_W-1 of the current block.
- BUSY  out  1  engine not IDLE, or FIFO not empty.
- BLK_CNT  out  16  count of blocks fully shifted out.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Reset values: IN_READY=0 while reset_n=1, then 1 from the first cycle after release. SOUT=0, SOUT_VAL=0, SOUT_LAST=0, BUSY=0, BLK_CNT=0. FIFO is emptied, state is IDLE, bit counter is 0.
- Push: on a rising edge with IN_VALID & IN_READY, IN_DATA is written to the FIFO. IN_READY = (count != FIFO_DEPTH), derived from registered count.
- Push and pop on the same edge leave count unchanged. A push is never accepted when full, even if a pop occurs on that edge.
- EN does not gate pushes.
- States: IDLE, SHIFT, GAP.
- IDLE: if EN=1 and the FIFO is not empty, pop into the shift register, clear the bit counter, go to SHIFT.
- SHIFT: SOUT = sreg[0] and SOUT_VAL = EN.
  - With EN=1: sreg shifts right by one and the counter increments each edge.
  - With EN=0: sreg, counter and state hold, and SOUT_VAL=0.
- SOUT_LAST = SHIFT & EN & (counter == BLOCK_W-1).
- On the edge completing the last bit, BLK_CNT increments (wraps 0xFFFF -> 0x0000). Next state:
  - GAP_CYCLES=0 and FIFO not empty: pop the next block and stay in SHIFT. No bubble; bit 0 of the next block follows on the next cycle.
  - GAP_CYCLES=0 and FIFO empty: IDLE.
  - GAP_CYCLES>0: GAP, with gap counter loaded.
- GAP: SOUT_VAL=0. The counter decrements only while EN=1. At 0, go to IDLE, which may pop on the following edge.
- Latency from an idle, empty block:
  - push at edge k;
  - pop at edge k+1;
  - bit 0 on SOUT with SOUT_VAL=1 in the cycle after edge k+1;
  - SOUT_LAST in the 128th valid cycle.
- SOUT is 0 whenever SOUT_VAL=0.
- Reset mid-block: the partial block and all FIFO contents are discarded. SOUT_VAL is 0 in the cycle after the reset edge. BLK_CNT is not incremented for the aborted block.
- BUSY = (state != IDLE) | (count != 0).

Test Plan:
1. Reset, then push 0x3243f6a8885a308d313198a2e0370734 with EN=1 -> SOUT_VAL high for exactly 128 consecutive cycles starting 2 edges after the push. First 8 SOUT bits are 0,0,1,0,1,1,0,0. Collected word equals input. SOUT_LAST only on the 128th bit. BLK_CNT=1.
2. Push 3 blocks back-to-back with IN_VALID held, GAP_CYCLES=0 -> IN_READY drops after 2 accepts and reasserts when block 1 is popped. Output is 384 contiguous valid bits with no bubble. BLK_CNT=3.
3. Drop EN for 5 cycles at bit 60 -> SOUT_VAL=0 for those 5 cycles, bit 60 resumes unchanged afterwards, and the total valid count is still 128.
4. GAP_CYCLES=3 with two queued blocks -> exactly 3 cycles with SOUT_VAL=0 between the block-1 SOUT_LAST and the block-2 bit 0.
5. Assert reset_n at bit 70 with one block queued -> outputs return to reset values in the next cycle. After release, no residual bits appear, BLK_CNT=0, BUSY=0.
6. Force BLK_CNT to 0xFFFF (or stream 65536 blocks) and complete one more block -> BLK_CNT=0x0000.
